// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_scheduler
//  Purpose  : Write-back scheduler in front of the register-file writer.
//             It merges two ALU write channels with queued memory-load
//             results onto the writer's two ports, keeping program order.
//             A newer ALU write to a register cancels older queued loads to
//             that register, so stale load data never overwrites it.
//  Ports    : CLK/nRST                 clock, async active-low reset
//             AluEn1/AluA1/AluD1       ALU Rd write (always accepted)
//             AluEn2/AluA2/AluD2       ALU Rs write (always accepted)
//             LdValid/LdAddr/LdData    returning load result
//             LdReady                  load FIFO not full
//             Flush                    synchronous FIFO clear
//             WrEn1/WrA1/WrD1          writer port 1 (registered)
//             WrEn2/WrA2/WrD2          writer port 2 (registered)
//             Pending                  FIFO occupancy, cancelled entries included
//             Drop                     cancelled entry retired (1-cycle pulse)
//  Revision : 1.0  initial release
// ============================================================================
module regfile_wb_scheduler #(
  parameter int DW    = 16,
  parameter int AW    = 1,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     AluEn1,
  input  logic [AW-1:0]            AluA1,
  input  logic [DW-1:0]            AluD1,
  input  logic                     AluEn2,
  input  logic [AW-1:0]            AluA2,
  input  logic [DW-1:0]            AluD2,
  input  logic                     LdValid,
  input  logic [AW-1:0]            LdAddr,
  input  logic [DW-1:0]            LdData,
  output logic                     LdReady,
  input  logic                     Flush,
  output logic                     WrEn1,
  output logic [AW-1:0]            WrA1,
  output logic [DW-1:0]            WrD1,
  output logic                     WrEn2,
  output logic [AW-1:0]            WrA2,
  output logic [DW-1:0]            WrD2,
  output logic [$clog2(DEPTH):0]   Pending,
  output logic                     Drop
);

  localparam int PW = $clog2(DEPTH);   // pointer width
  localparam int CW = PW + 1;          // occupancy width (0..DEPTH)

  // FIFO storage: valid bits carry the cancel state, so they need reset;
  // address/data are only meaningful while valid and are left unreset.
  logic [DEPTH-1:0] ent_valid;
  logic [AW-1:0]    ent_addr [DEPTH];
  logic [DW-1:0]    ent_data [DEPTH];

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;

  logic [DEPTH-1:0] kill;
  logic             push;
  logic             pop;
  logic             drop_nxt;
  logic             ld_p1;
  logic             ld_p2;
  logic             head_valid;
  logic             head_killed;
  logic [AW-1:0]    head_addr;
  logic [DW-1:0]    head_data;

  // Full is judged on the registered count only; a pop in the same cycle
  // does not open a slot for a push.
  assign LdReady = (count < CW'(DEPTH));
  assign Pending = count;
  assign push    = LdValid & LdReady & ~Flush;

  assign head_valid  = ent_valid[rd_ptr];
  assign head_killed = kill[rd_ptr];
  assign head_addr   = ent_addr[rd_ptr];
  assign head_data   = ent_data[rd_ptr];

  // An ALU write this cycle cancels every stored load to the same register.
  // The load being pushed this cycle is newer than the ALU write and is not
  // in storage yet, so it escapes the cancel.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_kill
      assign kill[i] = (AluEn1 && (ent_addr[i] == AluA1)) ||
                       (AluEn2 && (ent_addr[i] == AluA2));
    end
  endgenerate

  // Drain decision for the head entry. Cancelled heads retire without a
  // port; live heads prefer port 2, fall back to port 1, else stall.
  always_comb begin
    pop      = 1'b0;
    drop_nxt = 1'b0;
    ld_p1    = 1'b0;
    ld_p2    = 1'b0;
    if ((count != '0) && !Flush) begin
      if (!head_valid || head_killed) begin
        pop      = 1'b1;
        drop_nxt = 1'b1;
      end else if (!AluEn2) begin
        pop   = 1'b1;
        ld_p2 = 1'b1;
      end else if (!AluEn1) begin
        pop   = 1'b1;
        ld_p1 = 1'b1;
      end
    end
  end

  always_comb begin
    count_nxt = count;
    if (Flush) begin
      count_nxt = '0;
    end else if (push && !pop) begin
      count_nxt = count + CW'(1);
    end else if (!push && pop) begin
      count_nxt = count - CW'(1);
    end
  end

  // Per-entry valid bit: cancel, then retire on pop, then set on push.
  // Push and pop never target the same slot (pop needs count>0, push
  // needs count<DEPTH, and the slot under wr_ptr is free).
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          ent_valid[i] <= 1'b0;
        end else if (Flush) begin
          ent_valid[i] <= 1'b0;
        end else if (push && (wr_ptr == PW'(i))) begin
          ent_valid[i] <= 1'b1;
        end else if (pop && (rd_ptr == PW'(i))) begin
          ent_valid[i] <= 1'b0;
        end else if (kill[i]) begin
          ent_valid[i] <= 1'b0;
        end
      end

      always_ff @(posedge CLK) begin
        if (push && (wr_ptr == PW'(i))) begin
          ent_addr[i] <= LdAddr;
          ent_data[i] <= LdData;
        end
      end
    end
  endgenerate

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_nxt;
      if (Flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Registered writer ports. A load only takes a port the ALU left idle,
  // so each port carries at most one write per cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      WrEn1 <= 1'b0;
      WrA1  <= '0;
      WrD1  <= '0;
      WrEn2 <= 1'b0;
      WrA2  <= '0;
      WrD2  <= '0;
      Drop  <= 1'b0;
    end else begin
      WrEn1 <= AluEn1 | ld_p1;
      WrA1  <= ld_p1 ? head_addr : AluA1;
      WrD1  <= ld_p1 ? head_data : AluD1;
      WrEn2 <= AluEn2 | ld_p2;
      WrA2  <= ld_p2 ? head_addr : AluA2;
      WrD2  <= ld_p2 ? head_data : AluD2;
      Drop  <= drop_nxt;
    end
  end

endmodule
`default_nettype wire
